// File: rtl/mont_const_gen.sv
// Montgomery constant generator: computes R mod q and R^2 mod q, where R = 2^(8*(i+1)),
// by repeated modular doubling of x = 1 (shift plus one conditional subtract per cycle).
module mont_const_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] q,
  input  logic [1:0]  i,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] r_mod,
  output logic [31:0] r2_mod
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] q_reg, q_nxt;
  logic [31:0] x, x_nxt;
  logic [6:0]  cnt, cnt_nxt;
  logic [6:0]  n_len, n_nxt;
  logic        rej_pend, rej_pend_nxt;
  logic        busy_nxt, done_nxt, err_nxt;
  logic [31:0] r_nxt, r2_nxt;

  logic        q_valid;
  logic [2:0]  i_inc;
  logic [6:0]  n_req;
  logic [32:0] dbl;
  logic [31:0] diff;
  logic [31:0] x_red;
  logic        dbl_ge;

  // Only moduli accepted by the reducer's low-digit shortcut are allowed.
  assign q_valid = (q[7:0] == 8'h01) && (q > 32'd1);
  assign i_inc   = {1'b0, i} + 3'd1;
  assign n_req   = {1'b0, i_inc, 3'b000};

  // Since x < q, the doubled value is below 2q, so one subtract restores x < q and
  // the difference always fits in 32 bits.
  assign dbl    = {x, 1'b0};
  assign dbl_ge = (dbl >= {1'b0, q_reg});
  assign diff   = dbl[31:0] - q_reg;
  assign x_red  = dbl_ge ? diff : dbl[31:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      q_reg    <= '0;
      x        <= '0;
      cnt      <= '0;
      n_len    <= '0;
      rej_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      r_mod    <= '0;
      r2_mod   <= '0;
    end else begin
      state    <= state_nxt;
      q_reg    <= q_nxt;
      x        <= x_nxt;
      cnt      <= cnt_nxt;
      n_len    <= n_nxt;
      rej_pend <= rej_pend_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      r_mod    <= r_nxt;
      r2_mod   <= r2_nxt;
    end
  end

  // A rejected modulus passes through FIN twice: once to raise done/err, once to drop done.
  always_comb begin
    state_nxt    = state;
    q_nxt        = q_reg;
    x_nxt        = x;
    cnt_nxt      = cnt;
    n_nxt        = n_len;
    rej_pend_nxt = rej_pend;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    err_nxt      = err;
    r_nxt        = r_mod;
    r2_nxt       = r2_mod;

    unique case (state)
      IDLE: begin
        if (start) begin
          r_nxt   = '0;
          r2_nxt  = '0;
          err_nxt = 1'b0;
          if (q_valid) begin
            state_nxt = RUN;
            q_nxt     = q;
            n_nxt     = n_req;
            x_nxt     = 32'd1;
            cnt_nxt   = '0;
            busy_nxt  = 1'b1;
          end else begin
            state_nxt    = FIN;
            rej_pend_nxt = 1'b1;
          end
        end
      end

      RUN: begin
        x_nxt   = x_red;
        cnt_nxt = cnt + 7'd1;
        if (cnt == (n_len - 7'd1)) begin
          r_nxt = x_red;
        end
        if (cnt == ({n_len[5:0], 1'b0} - 7'd1)) begin
          r2_nxt    = x_red;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = FIN;
        end
      end

      FIN: begin
        if (rej_pend) begin
          rej_pend_nxt = 1'b0;
          done_nxt     = 1'b1;
          err_nxt      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mont_const_gen.sv
// Bench for mont_const_gen: arithmetic reference model checked every cycle,
// directed known-answer jobs, randomized jobs with mid-run disturbances, and a mid-run reset.
module tb_mont_const_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] q = '0;
  logic [1:0]  i = '0;
  logic        busy, done, err;
  logic [31:0] r_mod, r2_mod;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  mont_const_gen dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .q      (q),
    .i      (i),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .r_mod  (r_mod),
    .r2_mod (r2_mod)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit q_ok(input logic [31:0] qq);
    return (qq[7:0] == 8'h01) && (qq > 32'd1);
  endfunction

  function automatic logic [31:0] pow2_mod(input int n, input logic [31:0] qq);
    logic [63:0] v;
    v = 64'd1 << n;
    return 32'(v % {32'd0, qq});
  endfunction

  // Reference model: outputs as a function of edges since acceptance.
  int          m_mode = 0;
  int          m_k = 0;
  int          m_n = 0;
  logic        m_busy = 0, m_done = 0, m_err = 0, m_err_dc = 0;
  logic [31:0] m_r = '0, m_r2 = '0, res_r = '0, res_r2 = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_busy = 0; m_done = 0; m_err = 0; m_err_dc = 0;
      m_r = '0; m_r2 = '0;
    end else begin
      m_err_dc = 0;
      case (m_mode)
        0: if (start) begin
          m_r  = '0;
          m_r2 = '0;
          if (q_ok(q)) begin
            m_n    = 8 * (int'(i) + 1);
            res_r  = pow2_mod(m_n, q);
            res_r2 = 32'((64'(res_r) * 64'(res_r)) % {32'd0, q});
            m_err  = 0;
            m_busy = 1;
            m_k    = 0;
            m_mode = 1;
          end else begin
            m_err_dc = 1;
            m_mode   = 2;
          end
        end
        1: begin
          m_k++;
          if (m_k == m_n) m_r = res_r;
          if (m_k == 2 * m_n) begin
            m_r2 = res_r2; m_done = 1; m_busy = 0; m_mode = 3;
          end
        end
        2: begin m_done = 1; m_err = 1; m_mode = 3; end
        default: begin m_done = 0; m_mode = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset && chk_en) begin
      checkOutput("busy", busy, m_busy);
      checkOutput("done", done, m_done);
      if (!m_err_dc) checkOutput("err", err, m_err);
      checkOutput("r_mod", r_mod, m_r);
      checkOutput("r2_mod", r2_mod, m_r2);
    end
  end

  // Issue one start pulse and wait (bounded) for done; reports latency and busy cycles.
  task automatic applyStimulus(input logic [31:0] qq, input logic [1:0] ii, input bit perturb,
                               output int lat, output int busy_cyc);
    @(negedge clk);
    start = 1'b1; q = qq; i = ii;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cyc = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 80; k++) begin
      if (perturb && k == 5) begin start = 1'b1; q = $urandom; i = 2'($urandom); end
      if (perturb && k == 6) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
      if (busy) busy_cyc++;
    end
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 80 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic runKnown(input string tag, input logic [31:0] qq, input logic [1:0] ii,
                          input bit perturb, input int exp_lat,
                          input logic [31:0] exp_r, input logic [31:0] exp_r2, input bit exp_err);
    int lat, bc;
    applyStimulus(qq, ii, perturb, lat, bc);
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_busy_cycles"}, bc, exp_err ? 0 : exp_lat);
    checkOutput({tag, "_r_mod"}, r_mod, exp_r);
    checkOutput({tag, "_r2_mod"}, r2_mod, exp_r2);
    checkOutput({tag, "_err"}, err, exp_err);
  endtask

  initial begin
    int lat, bc;
    logic [31:0] rq;
    logic [1:0]  ri;

    checkOutput("model_pin_r_3329_16", pow2_mod(16, 32'd3329), 64'd2285);
    checkOutput("model_pin_r_8380417_24", pow2_mod(24, 32'd8380417), 64'd16382);
    checkOutput("model_pin_r_257_8", pow2_mod(8, 32'd257), 64'd256);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_r_mod", r_mod, 0);
    checkOutput("reset_r2_mod", r2_mod, 0);
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;

    runKnown("q3329_i1", 32'd3329, 2'd1, 1'b0, 32, 32'd2285, 32'd1353, 1'b0);
    runKnown("q3329_i3", 32'd3329, 2'd3, 1'b0, 64, 32'd1353, 32'd2988, 1'b0);
    runKnown("q8380417_i2", 32'd8380417, 2'd2, 1'b0, 48, 32'd16382, 32'd196580, 1'b0);
    runKnown("q257_i0", 32'd257, 2'd0, 1'b0, 16, 32'd256, 32'd1, 1'b0);
    runKnown("q3329_i1_again", 32'd3329, 2'd1, 1'b0, 32, 32'd2285, 32'd1353, 1'b0);
    runKnown("bad_3328", 32'd3328, 2'd1, 1'b0, 1, 32'd0, 32'd0, 1'b1);
    runKnown("bad_1", 32'd1, 2'd2, 1'b0, 1, 32'd0, 32'd0, 1'b1);
    runKnown("bad_103", 32'h0000_0103, 2'd3, 1'b0, 1, 32'd0, 32'd0, 1'b1);
    runKnown("perturbed", 32'd3329, 2'd1, 1'b1, 32, 32'd2285, 32'd1353, 1'b0);

    // Abort an i=3 run with reset at cycle 10.
    @(negedge clk);
    start = 1'b1; q = 32'd3329; i = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_err", err, 0);
    checkOutput("abort_r_mod", r_mod, 0);
    checkOutput("abort_r2_mod", r2_mod, 0);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("abort_no_done", done, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (70) begin
      @(posedge clk); #1;
      checkOutput("post_abort_no_done", done, 0);
    end
    runKnown("after_reset", 32'd3329, 2'd1, 1'b0, 32, 32'd2285, 32'd1353, 1'b0);

    for (int n = 0; n < 20; n++) begin
      rq = $urandom;
      if ($urandom_range(0, 3) != 0) rq[7:0] = 8'h01;
      ri = 2'($urandom_range(0, 3));
      applyStimulus(rq, ri, bit'($urandom_range(0, 1)), lat, bc);
      checkOutput("rand_latency", lat, q_ok(rq) ? 16 * (int'(ri) + 1) : 1);
      checkOutput("rand_busy_cycles", bc, q_ok(rq) ? 16 * (int'(ri) + 1) : 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mont_const_gen.md
# mont_const_gen

Generates the Montgomery-domain constants R mod q and R² mod q for the word-serial Montgomery reducer. Here R = 2^(8·(i+1)), with i the same 2-bit digit-count select the reducer uses. The reducer strips one factor of R. This block supplies the R factors needed to enter the Montgomery domain (operand·R² → reducer → operand·R) and to build twiddle tables. It runs once per modulus or width change, ahead of the NTT datapath. It uses a sequential shift/conditional-subtract FSM with no multiplier.

## Interface
- No parameters; widths fixed to the 32-bit datapath of the reducer.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; all state and outputs clear immediately on assertion.
- start  input  1  request; sampled only in IDLE.
- q  input  32  modulus; latched on accepted start.
- i  input  2  digit-count select, latched on accepted start: 0→8-bit, 1→16-bit, 2→24-bit, 3→32-bit R.
- busy  output  1  high while the computation runs.
- done  output  1  one-cycle completion pulse.
- err  output  1  modulus rejected; valid with done, held until the next accepted start.
- r_mod  output  32  R mod q; valid from done, held until the next accepted start.
- r2_mod  output  32  R² mod q; valid from done, held until the next accepted start.

## Operation
- States: IDLE, RUN, FIN.
- IDLE, start=1, q valid → RUN. Latch q and N = 8·(i+1). Set x=1, cnt=0. Clear r_mod, r2_mod and err.
- IDLE, start=1, q invalid → FIN. Set err=1 and r_mod=r2_mod=0.
- q is valid only if q[0]=1, q[7:0]=8'h01 (the reducer's digit trick) and q>1. Anything else is invalid.
- RUN, each cycle: t = {x,1'b0} (33-bit). x ← (t ≥ q) ? t−q : t. Then cnt ← cnt+1.
  - Invariant: x < q, so t < 2^33 and one subtract suffices.
  - The compare is 33-bit unsigned against {1'b0,q}.
- Capture x into r_mod on the doubling where cnt = N−1, i.e. the Nth doubling.
- Capture x into r2_mod on the doubling where cnt = 2N−1, then go to FIN.
- FIN: assert done for one cycle, then → IDLE.
- start is ignored while busy or in FIN. Changes on q and i after acceptance have no effect.
- start held high continuously: a new run is accepted on the first IDLE cycle after FIN.
- reset mid-run aborts the run: state → IDLE, all outputs 0, and no done pulse.

## Timing
- Reset values: busy=0, done=0, err=0, r_mod=0, r2_mod=0, state IDLE.
- Let E0 be the edge that accepts start.
- Valid q:
  - busy=1 from E0 to E(2N).
  - r_mod updates at E(N).
  - r2_mod updates at E(2N) and done=1 from E(2N) to E(2N+1).
  - Start-to-done latency is 2N cycles: 16, 32, 48 or 64 for i=0..3.
- Invalid q: done=1 and err=1 from E1 to E2. busy stays 0.
- Earliest next acceptance is the edge after done falls.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- q=3329, i=1 → done at E32. r_mod=2285, r2_mod=1353, err=0. busy high for exactly 32 cycles.
- q=3329, i=3 → done at E64. r_mod=1353, r2_mod=2988.
- q=8380417, i=2 → done at E48. r_mod=16382, r2_mod=196580.
- q=257, i=0 → done at E16. r_mod=256, r2_mod=1. Then issue a second start with q=3329, i=1 while the outputs are held: r_mod and r2_mod clear at acceptance, then give the i=1 results.
- Invalid q:
  - q=3328 → done and err at E1; r_mod=r2_mod=0.
  - q=1 → same response.
  - q=0x00000103 (q[7:0]≠8'h01) → same response.
- Protocol and reset:
  - Pulse start again mid-run, and change q and i mid-run → results unchanged.
  - Drop reset at cycle 10 of an i=3 run → all outputs 0 immediately and no done pulse.
  - Start again after reset → correct results.
